// File: rtl/bar_level_builder_if.sv
// Magnitude sample stream into the bar level builder: valid/ready handshake
// carrying a bar index and an unsigned 16-bit magnitude.
interface bar_level_builder_if;
    logic        mag_valid;
    logic        mag_ready;
    logic [3:0]  mag_bin;
    logic [15:0] mag_data;

    modport master (
        output mag_valid,
        output mag_bin,
        output mag_data,
        input  mag_ready
    );

    modport slave (
        input  mag_valid,
        input  mag_bin,
        input  mag_data,
        output mag_ready
    );
endinterface

// File: rtl/bar_level_builder.sv
// Per-frame bar level builder: max-per-bar, log2 level, rise-fast/fall-slow, atomic commit.
// Optional peak-hold markers are enabled with `define BAR_PEAK_HOLD_EN.
module bar_level_builder #(
    parameter int unsigned DECAY_FRAMES = 4,
    parameter logic [15:0] NOISE_FLOOR  = 16'd0
) (
    input  logic                 fsm_clk,
    input  logic                 reset,
    input  logic                 frame_tick,
    bar_level_builder_if.slave   mag,
    output logic [15:0]          bars [16],
    output logic                 bars_update,
    output logic                 overrun
);

    typedef enum logic [1:0] {COLLECT, CONVERT, COMMIT} state_t;

    localparam logic [7:0] DECAY_LAST = 8'(DECAY_FRAMES - 1);

    state_t      state_reg, state_next;
    logic [3:0]  idx_reg;
    logic [7:0]  decay_cnt_reg;
    logic        decay_frame_reg;
    logic        overrun_reg;
    logic        bars_update_reg;

    logic [15:0] max_all  [16];
    logic [4:0]  disp_all [16];
    logic [15:0] cur_max;
    logic [4:0]  cur_disp;
    logic [4:0]  raw;
    logic [4:0]  disp_next;
    logic        accept;
    logic        tick_accept;
    logic        converting;

    function automatic logic [4:0] log_level(input logic [15:0] m);
        log_level = '0;
        if (m > NOISE_FLOOR) begin
            for (int b = 0; b < 16; b++) begin
                if (m[b]) log_level = 5'(b + 1);
            end
        end
    endfunction

    function automatic logic [15:0] therm(input logic [4:0] lvl);
        therm = '0;
        for (int k = 0; k < 16; k++) begin
            therm[k] = (5'(k) < lvl);
        end
    endfunction

    assign mag.mag_ready = (state_reg == COLLECT);
    assign accept        = mag.mag_valid && (state_reg == COLLECT);
    assign tick_accept   = frame_tick && (state_reg == COLLECT);
    assign converting    = (state_reg == CONVERT);
    assign bars_update   = bars_update_reg;
    assign overrun       = overrun_reg;

    always_ff @(posedge fsm_clk) begin
        if (reset) state_reg <= COLLECT;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            COLLECT: if (frame_tick) state_next = CONVERT;
            CONVERT: if (idx_reg == 4'd15) state_next = COMMIT;
            COMMIT:  state_next = COLLECT;
            default: state_next = COLLECT;
        endcase
    end

    // The decay decision is latched at frame close so the whole conversion pass agrees on it.
    always_ff @(posedge fsm_clk) begin
        if (reset) begin
            idx_reg         <= '0;
            decay_cnt_reg   <= '0;
            decay_frame_reg <= 1'b0;
            overrun_reg     <= 1'b0;
            bars_update_reg <= 1'b0;
        end else begin
            bars_update_reg <= (state_reg == COMMIT);
            if (tick_accept) begin
                idx_reg         <= '0;
                decay_frame_reg <= (decay_cnt_reg == DECAY_LAST);
                decay_cnt_reg   <= (decay_cnt_reg == DECAY_LAST) ? 8'd0 : decay_cnt_reg + 8'd1;
            end else if (converting) begin
                idx_reg <= idx_reg + 4'd1;
            end
            if (frame_tick && (state_reg != COLLECT)) overrun_reg <= 1'b1;
        end
    end

    always_comb begin
        cur_max  = max_all[idx_reg];
        cur_disp = disp_all[idx_reg];
        raw      = log_level(cur_max);
        if (raw >= cur_disp)      disp_next = raw;
        else if (decay_frame_reg) disp_next = cur_disp - 5'd1;
        else                      disp_next = cur_disp;
    end

`ifdef BAR_PEAK_HOLD_EN
    localparam logic [8:0] HOLD_RELOAD = 9'(2 * DECAY_FRAMES);

    logic [4:0] pk_all   [16];
    logic [8:0] hold_all [16];
    logic [4:0] cur_pk;
    logic [8:0] cur_hold;
    logic [4:0] pk_next;
    logic [8:0] hold_next;

    // Peak only drops after its hold expires, and never below the freshly computed bar level.
    always_comb begin
        cur_pk    = pk_all[idx_reg];
        cur_hold  = hold_all[idx_reg];
        pk_next   = cur_pk;
        hold_next = cur_hold;
        if (raw > cur_pk) begin
            pk_next   = raw;
            hold_next = HOLD_RELOAD;
        end else if (cur_hold != 9'd0) begin
            hold_next = cur_hold - 9'd1;
        end else if (decay_frame_reg && (cur_pk > disp_next)) begin
            pk_next = cur_pk - 5'd1;
        end
    end
`endif

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_bar
            logic [15:0] max_reg;
            logic [4:0]  disp_reg;
            logic [15:0] bars_reg;
            logic [15:0] row;
            logic        sel;

            assign sel          = converting && (idx_reg == 4'(gi));
            assign max_all[gi]  = max_reg;
            assign disp_all[gi] = disp_reg;
            assign bars[gi]     = bars_reg;

`ifdef BAR_PEAK_HOLD_EN
            logic [4:0] pk_reg;
            logic [8:0] hold_reg;

            assign pk_all[gi]   = pk_reg;
            assign hold_all[gi] = hold_reg;

            always_ff @(posedge fsm_clk) begin
                if (reset) begin
                    pk_reg   <= '0;
                    hold_reg <= '0;
                end else if (sel) begin
                    pk_reg   <= pk_next;
                    hold_reg <= hold_next;
                end
            end

            always_comb begin
                row = therm(disp_reg);
                if (pk_reg > disp_reg) row[4'(pk_reg - 5'd1)] = 1'b1;
            end
`else
            always_comb begin
                row = therm(disp_reg);
            end
`endif

            always_ff @(posedge fsm_clk) begin
                if (reset) begin
                    max_reg  <= '0;
                    disp_reg <= '0;
                    bars_reg <= '0;
                end else begin
                    if (accept && (mag.mag_bin == 4'(gi)) && (mag.mag_data > max_reg))
                        max_reg <= mag.mag_data;
                    else if (sel)
                        max_reg <= '0;
                    if (sel) disp_reg <= disp_next;
                    if (state_reg == COMMIT) bars_reg <= row;
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_bar_level_builder.sv
// Directed bench for bar_level_builder: the stimulus queues the expected bar frame,
// and a monitor compares it on every bars_update pulse.
module tb_bar_level_builder;

    logic        fsm_clk = 1'b0;
    logic        reset   = 1'b1;
    logic        frame_tick = 1'b0;
    logic [15:0] bars [16];
    logic        bars_update;
    logic        overrun;

    bar_level_builder_if mag_if ();

    bar_level_builder #(
        .DECAY_FRAMES (4),
        .NOISE_FLOOR  (16'd0)
    ) dut (
        .fsm_clk     (fsm_clk),
        .reset       (reset),
        .frame_tick  (frame_tick),
        .mag         (mag_if.slave),
        .bars        (bars),
        .bars_update (bars_update),
        .overrun     (overrun)
    );

    always #5 fsm_clk = ~fsm_clk;

    typedef struct packed {
        logic [15:0][15:0] rows;
        int                cyc;
    } exp_t;

    exp_t              sb [$];
    logic [15:0][15:0] exp_rows;
    int                cyc = 0;
    int                tests = 0;
    int                fails = 0;

    always @(posedge fsm_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: pop the expected frame whenever the DUT commits a new one.
    always @(negedge fsm_clk) begin
        if (!reset && bars_update) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL unexpected_update: bars_update at cycle %0d, none expected", cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("[TB] update cycle %0d: bars[0]=%h bars[3]=%h bars[5]=%h bars[15]=%h",
                         cyc, bars[0], bars[3], bars[5], bars[15]);
                check("latency", cyc, e.cyc);
                for (int i = 0; i < 16; i++)
                    check($sformatf("bars[%0d]", i), bars[i], e.rows[i]);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic clear_exp();
        exp_rows = '0;
    endtask

    task automatic pulse_reset();
        @(posedge fsm_clk); #1;
        reset = 1'b1;
        @(posedge fsm_clk); #1;
        reset = 1'b0;
    endtask

    task automatic send_sample(input logic [3:0] bin, input logic [15:0] data);
        @(posedge fsm_clk); #1;
        mag_if.mag_valid = 1'b1;
        mag_if.mag_bin   = bin;
        mag_if.mag_data  = data;
        @(posedge fsm_clk); #1;
        mag_if.mag_valid = 1'b0;
        mag_if.mag_data  = 16'hDEAD;
    endtask

    // Close a frame; optionally carry a same-cycle sample and/or a late tick during CONVERT.
    task automatic run_frame(input bit late, input bit with_sample,
                             input logic [3:0] sbin, input logic [15:0] sdata);
        exp_t e;
        int   low;
        @(posedge fsm_clk); #1;
        frame_tick = 1'b1;
        if (with_sample) begin
            mag_if.mag_valid = 1'b1;
            mag_if.mag_bin   = sbin;
            mag_if.mag_data  = sdata;
        end
        e.rows = exp_rows;
        e.cyc  = cyc + 18;
        sb.push_back(e);
        @(posedge fsm_clk); #1;
        frame_tick       = 1'b0;
        mag_if.mag_valid = 1'b0;
        low = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge fsm_clk);
            frame_tick = late && (i == 5);
            if (mag_if.mag_ready) break;
            low++;
        end
        frame_tick = 1'b0;
        check("ready_low_cycles", low, 17);
    endtask

    initial begin
        mag_if.mag_valid = 1'b0;
        mag_if.mag_bin   = 4'd0;
        mag_if.mag_data  = 16'd0;
        repeat (3) @(posedge fsm_clk);
        #1 reset = 1'b0;
        @(negedge fsm_clk);
        for (int i = 0; i < 16; i++) check($sformatf("reset_bars[%0d]", i), bars[i], 16'h0000);
        check("reset_ready", mag_if.mag_ready, 1'b1);
        check("reset_overrun", overrun, 1'b0);
        check("reset_update", bars_update, 1'b0);

        // Idle frame.
        clear_exp();
        run_frame(1'b0, 1'b0, 4'd0, 16'd0);
        check("idle_overrun", overrun, 1'b0);

        // Level mapping: max 200 -> level 8; 0xFFFF -> level 16.
        send_sample(4'd3, 16'd5);
        send_sample(4'd3, 16'd200);
        send_sample(4'd3, 16'd40);
        send_sample(4'd15, 16'hFFFF);
        clear_exp();
        exp_rows[3]  = 16'h00FF;
        exp_rows[15] = 16'hFFFF;
        run_frame(1'b0, 1'b0, 4'd0, 16'd0);

        // Decay with DECAY_FRAMES=4 from a clean counter.
        pulse_reset();
        send_sample(4'd0, 16'd600);
        clear_exp();
        exp_rows[0] = 16'h03FF;
        run_frame(1'b0, 1'b0, 4'd0, 16'd0);
        run_frame(1'b0, 1'b0, 4'd0, 16'd0);
        run_frame(1'b0, 1'b0, 4'd0, 16'd0);
        exp_rows[0] = 16'h01FF;
        run_frame(1'b0, 1'b0, 4'd0, 16'd0);
        send_sample(4'd0, 16'h8000);
        exp_rows[0] = 16'hFFFF;
        run_frame(1'b0, 1'b0, 4'd0, 16'd0);

        // Sample in the same cycle as frame_tick belongs to the closing frame.
        exp_rows[5] = 16'h0001;
        run_frame(1'b0, 1'b1, 4'd5, 16'd1);

        // Late tick during CONVERT: ignored, overrun set, counter not advanced.
        run_frame(1'b1, 1'b0, 4'd0, 16'd0);
        check("late_tick_overrun", overrun, 1'b1);
        exp_rows[0] = 16'h7FFF;
        exp_rows[5] = 16'h0000;
        run_frame(1'b0, 1'b0, 4'd0, 16'd0);

        // Reset at CONVERT cycle 8 aborts the update.
        @(posedge fsm_clk); #1;
        frame_tick = 1'b1;
        @(posedge fsm_clk); #1;
        frame_tick = 1'b0;
        repeat (8) @(posedge fsm_clk);
        #1 reset = 1'b1;
        @(posedge fsm_clk); #1;
        reset = 1'b0;
        @(negedge fsm_clk);
        for (int i = 0; i < 16; i++) check($sformatf("abort_bars[%0d]", i), bars[i], 16'h0000);
        check("abort_ready", mag_if.mag_ready, 1'b1);
        check("abort_overrun", overrun, 1'b0);
        check("abort_update", bars_update, 1'b0);
        repeat (25) @(posedge fsm_clk);

        // Displayed levels were cleared by the reset.
        clear_exp();
        run_frame(1'b0, 1'b0, 4'd0, 16'd0);

        repeat (5) @(posedge fsm_clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
